// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and next-state function for the "1010"
// overlapping Mealy detector used by seq_det_rr_scheduler.
//   det_state_e  : 2-bit context encoding (A idle, B "1", C "10", D "101")
//   RST_STATE    : context value after reset or ch_clr
//   next_state_f : {next state, hit} for a presented bit
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_A = 2'd0,
    ST_B = 2'd1,
    ST_C = 2'd2,
    ST_D = 2'd3
  } det_state_e;

  localparam det_state_e RST_STATE = ST_A;

  typedef struct packed {
    det_state_e nxt;
    logic       hit;
  } det_res_t;

  // Overlap: a hit from D leaves the context in C ("10" already seen).
  function automatic det_res_t next_state_f(input det_state_e s, input logic x);
    det_res_t r;
    r.hit = 1'b0;
    r.nxt = RST_STATE;
    case (s)
      ST_A: r.nxt = x ? ST_B : ST_A;
      ST_B: r.nxt = x ? ST_B : ST_C;
      ST_C: r.nxt = x ? ST_D : ST_A;
      ST_D: begin
        r.nxt = x ? ST_B : ST_C;
        r.hit = ~x;
      end
      default: r.nxt = RST_STATE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_det_core.sv
// seq_det_core: purely combinational detector step, shared by all channels.
// Ports:
//   cur  : context of the granted channel (already forced to A on clear)
//   x    : presented bit
//   nxt  : context to write back
//   hit  : "1010" completed with this bit
module seq_det_core
  import seq_det_pkg::*;
(
  input  det_state_e cur,
  input  logic       x,
  output det_state_e nxt,
  output logic       hit
);

  det_res_t res;

  assign res = next_state_f(cur, x);
  assign nxt = res.nxt;
  assign hit = res.hit;

endmodule

// File: rtl/seq_det_rr_scheduler.sv
// seq_det_rr_scheduler: one "1010" detection engine time-shared among
// NUM_CH serial requesters via round-robin grant, with per-channel saved
// context so each stream is detected independently.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   req_valid / req_bit  : per-channel request and serial bit
//   req_ready            : one-hot combinational grant (0 if nothing valid)
//   ch_clr               : per-channel synchronous context clear
//   det_valid/ch/hit     : registered result of last cycle's consumed bit
// Optional (macro SEQ_DET_HIT_COUNT_EN):
//   cnt_sel / cnt_rd     : combinational read of per-channel saturating
//                          CNT_W-bit hit counters
module seq_det_rr_scheduler
  import seq_det_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req_valid,
  input  logic [NUM_CH-1:0] req_bit,
  output logic [NUM_CH-1:0] req_ready,
  input  logic [NUM_CH-1:0] ch_clr,
  output logic              det_valid,
  output logic [CH_W-1:0]   det_ch,
  output logic              det_hit
`ifdef SEQ_DET_HIT_COUNT_EN
  ,
  input  logic [CH_W-1:0]   cnt_sel,
  output logic [CNT_W-1:0]  cnt_rd
`endif
);

  localparam int STAGES = 1;

  if (NUM_CH < 2 || NUM_CH > 16 || CNT_W < 1) begin : g_bad_cfg
    $error("seq_det_rr_scheduler: unsupported NUM_CH/CNT_W");
  end

  logic [NUM_CH-1:0][1:0] ctx;
  logic [CH_W-1:0]        rr_ptr;
  logic                   grant_any;
  logic [CH_W-1:0]        grant_idx;
  logic [STAGES:0]        vld_pipe;
  det_state_e             core_cur;
  det_state_e             core_nxt;
  logic                   core_hit;

  // Rotating priority: scan rr_ptr+1 .. rr_ptr+NUM_CH (mod NUM_CH).
  // Scanning downward lets the nearest valid channel overwrite the rest.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req_valid[CH_W'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = CH_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign vld_pipe[0] = grant_any;

  // A clear colliding with a grant evaluates the bit from the idle state.
  assign core_cur = ch_clr[grant_idx] ? RST_STATE : det_state_e'(ctx[grant_idx]);

  seq_det_core u_core (
    .cur (core_cur),
    .x   (req_bit[grant_idx]),
    .nxt (core_nxt),
    .hit (core_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) ctx[i] <= RST_STATE;
      rr_ptr <= CH_W'(NUM_CH - 1);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant_any && grant_idx == CH_W'(i)) ctx[i] <= core_nxt;
        else if (ch_clr[i])                    ctx[i] <= RST_STATE;
      end
      if (grant_any) rr_ptr <= grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      det_ch             <= '0;
      det_hit            <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (grant_any) begin
        det_ch  <= grant_idx;
        det_hit <= core_hit;
      end
    end
  end

  assign det_valid = vld_pipe[STAGES];

`ifdef SEQ_DET_HIT_COUNT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] hit_cnt;

  // Clear beats a same-cycle hit; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_clr[i])
          hit_cnt[i] <= '0;
        else if (grant_any && grant_idx == CH_W'(i) && core_hit && !(&hit_cnt[i]))
          hit_cnt[i] <= hit_cnt[i] + 1'b1;
      end
    end
  end

  assign cnt_rd = hit_cnt[cnt_sel];
`endif

endmodule

// File: doc/seq_det_rr_scheduler.md
Name: seq_det_rr_scheduler

Overview:
- Shares one overlapping Mealy "1010" detection engine among NUM_CH serial bit-stream requesters.
- Round-robin arbitration grants one requester's bit per cycle.
- Each channel's FSM state is saved in a per-channel context register, so every stream is detected independently, as if it had its own detector.
- Sits between the serial front-end channels and the event/interrupt collector.

Parameters:
- NUM_CH, 4, number of requester channels (2..16).
- CH_W, $clog2(NUM_CH), width of the channel index.
- CNT_W, 8, hit-counter width (used only with the optional feature).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_CH  channel i has a bit to present.
- req_bit  input  NUM_CH  serial bit of channel i.
- req_ready  output  NUM_CH  one-hot grant; a bit is consumed when req_valid[i] && req_ready[i].
- ch_clr  input  NUM_CH  per-channel synchronous context clear.
- det_valid  output  1  registered: a bit was processed last cycle.
- det_ch  output  CH_W  channel of that bit.
- det_hit  output  1  "1010" completed on det_ch with that bit.

Behaviour:
- Reset (async, rst_n=0):
  - All contexts = A.
  - rr_ptr = NUM_CH-1, so channel 0 has first priority.
  - det_valid=0, det_ch=0, det_hit=0.
  - req_ready is combinational and is 0 while no request is valid.
- Context encoding (2 bits): A=idle, B=seen 1, C=seen 10, D=seen 101.
- Next-state function (x = presented bit):
  - A: 0->A, 1->B.
  - B: 0->C, 1->B.
  - C: 0->A, 1->D.
  - D: 0->C with hit=1, 1->B.
  - Overlap: after a hit, the context is C, so "101010" yields two hits.
- Arbitration:
  - Combinational.
  - Grant the first i with req_valid[i]=1, searching from rr_ptr+1 upward and wrapping modulo NUM_CH.
  - req_ready = onehot(grant), or 0 when no request is valid.
  - At most one grant per cycle.
- On grant g at a clock edge:
  - context[g] <= next_state(context[g], req_bit[g]).
  - rr_ptr <= g.
  - det_valid <= 1, det_ch <= g, det_hit <= hit.
  - Latency: 1 cycle from the consume edge to the output.
- No grant:
  - det_valid <= 0.
  - det_ch and det_hit hold their values.
  - rr_ptr is unchanged.
- req_valid may drop without being granted; no state changes.
- Held requester: a channel holding valid is served at least once every NUM_CH cycles.
- ch_clr[i]=1 with channel i not granted: context[i] <= A.
- ch_clr[i]=1 in the same cycle as a grant to i:
  - The bit is evaluated from state A, so hit=0.
  - context[i] <= next_state(A, bit).
- Context is only ever written with an encoded state; the default branch maps to A.
- rst_n asserted mid-stream: the partial pattern is lost and all contexts return to A immediately.

Optional Feature:
- Macro: SEQ_DET_HIT_COUNT_EN.
- When defined:
  - Adds per-channel CNT_W-bit saturating hit counters, reset 0.
  - Each counter increments on every hit for its channel and saturates at all-ones.
  - ch_clr[i] zeroes counter i; if a hit occurs in the same cycle, clear wins.
  - Adds ports cnt_sel input CH_W and cnt_rd output CNT_W.
  - cnt_rd = counter[cnt_sel], combinational.
- When undefined: no counters and no extra ports; behaviour otherwise identical.

Decomposition:
- Package seq_det_pkg holds:
  - typedef of the 2-bit state enum A/B/C/D and the value RST_STATE=A.
  - function next_state_f(state, x) returning {next, hit}.
- Sub-module seq_det_core: purely combinational next-state/hit logic, instantiated once and shared by all channels.
- The round-robin arbiter stays inline.

Test Plan:
1. Single stream: ch0 valid every cycle, bits 1,0,1,0,1,0 -> det_hit=1 on the 4th and 6th outputs, det_ch=0, one cycle after each consume.
2. Interleaving: ch0 and ch1 both valid, ch0 stream 1010, ch1 stream 0000 -> grants alternate 0,1,0,1,...; the hit appears only with det_ch=0 on ch0's 4th bit, proving context isolation.
3. Fairness: all 4 channels valid continuously -> req_ready cycles 0001,0010,0100,1000,0001; no channel waits more than 4 cycles.
4. Clear collision: ch2 has consumed 101, then ch_clr[2]=1 with bit 0 granted the same cycle -> det_hit=0; next bits 1,0,1,0 hit on the 4th.
5. Reset mid-stream: ch0 after 101, rst_n pulsed low asynchronously -> outputs 0 immediately; a following single 0 gives no hit.
6. With SEQ_DET_HIT_COUNT_EN and CNT_W=2: 5 overlapping hits on ch3 -> cnt_rd (cnt_sel=3) reads 1,2,3,3,3.
